// File: rtl/baseball_pkg.sv
// Shared number-baseball definitions: FSM states, digit geometry and the
// "four distinct BCD digits" rule used for both questions and secrets.
package baseball_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGIT  = 9;
  localparam int SCORE_W    = 3;
  localparam int WORD_W     = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REPLY,
    DONE
  } state_t;

  // Position 0 is the most significant nibble.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx);
    case (idx)
      2'd0:    return word[15:12];
      2'd1:    return word[11:8];
      2'd2:    return word[7:4];
      default: return word[3:0];
    endcase
  endfunction

  // True when every digit is 0..9 and no digit repeats.
  function automatic logic digits_valid(input logic [WORD_W-1:0] word);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_at(word, 2'(i)) > DIGIT_W'(MAX_DIGIT)) ok = 1'b0;
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (digit_at(word, 2'(i)) == digit_at(word, 2'(j))) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bb_digit_match.sv
// Scores a single question digit against the whole secret: strike when it
// matches the secret digit at its own position, ball when it matches any
// other secret digit.
module bb_digit_match
  import baseball_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic [1:0]         i_idx,
  input  logic [WORD_W-1:0]  i_secret,
  output logic               o_is_strike,
  output logic               o_is_ball
);

  // Positional match first; a strike never also counts as a ball.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves it unassigned, which would infer a latch.
    o_is_strike = (i_digit == digit_at(i_secret, i_idx));
    o_is_ball   = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((2'(j) != i_idx) && (i_digit == digit_at(i_secret, 2'(j)))) o_is_ball = 1'b1;
    end
    if (o_is_strike) o_is_ball = 1'b0;
  end

endmodule

// File: rtl/grader.sv
// Responder side of the number-baseball interface. Accepts one question,
// scores it one digit per cycle, returns the reply with a valid/ack
// handshake and tracks the number of valid questions asked this game.
module grader
  import baseball_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SECRET = 16'h0123,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ask_valid,
  input  logic             ask_ready,
  input  logic [15:0]      question,
  input  logic             secret_load,
  input  logic [15:0]      secret_in,
  output logic             reply_ready,
  output logic             reply_valid,
  output logic [2:0]       strike,
  output logic [2:0]       ball,
  output logic             correct,
  output logic             invalid,
  output logic [CNT_W-1:0] cnt,
  output logic             secret_err
);

  state_t r_state, w_next_state;

  logic [WORD_W-1:0]  r_secret;
  logic [WORD_W-1:0]  r_q;
  logic [1:0]         r_idx;
  logic [SCORE_W-1:0] r_acc_strike, r_acc_ball;
  logic               r_acc_invalid;
  logic [SCORE_W-1:0] r_strike, r_ball;
  logic               r_correct, r_invalid, r_secret_err;
  logic [CNT_W-1:0]   r_cnt;

  logic [DIGIT_W-1:0] w_digit;
  logic               w_digit_bad;
  logic               w_is_strike, w_is_ball;
  logic [SCORE_W-1:0] w_next_strike, w_next_ball;
  logic               w_next_invalid;
  logic               w_load_window, w_secret_ok, w_load, w_reject, w_accept;

  // Single shared matcher; the current digit is selected by idx.
  bb_digit_match u_match (
    .i_digit     (w_digit),
    .i_idx       (r_idx),
    .i_secret    (r_secret),
    .o_is_strike (w_is_strike),
    .o_is_ball   (w_is_ball)
  );

  // Current digit, its malformation check and the updated accumulators.
  always_comb begin
    w_digit     = digit_at(r_q, r_idx);
    w_digit_bad = (w_digit > DIGIT_W'(MAX_DIGIT));
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((2'(j) != r_idx) && (w_digit == digit_at(r_q, 2'(j)))) w_digit_bad = 1'b1;
    end
    w_next_invalid = r_acc_invalid | w_digit_bad;
    w_next_strike  = r_acc_strike + {2'b00, (~w_digit_bad & w_is_strike)};
    w_next_ball    = r_acc_ball   + {2'b00, (~w_digit_bad & w_is_ball)};
  end

  // Handshake qualifiers; a secret_load in IDLE pre-empts question acceptance.
  always_comb begin
    w_load_window = (r_state == IDLE) || (r_state == DONE);
    w_secret_ok   = digits_valid(secret_in);
    w_load        = w_load_window & secret_load & w_secret_ok;
    w_reject      = w_load_window & secret_load & ~w_secret_ok;
    w_accept      = (r_state == IDLE) & ask_valid & ~secret_load;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic and handshake outputs decoded from state.
  always_comb begin
    w_next_state = r_state;
    reply_ready  = (r_state == IDLE);
    reply_valid  = (r_state == REPLY);
    case (r_state)
      IDLE:    if (w_load) w_next_state = IDLE;
               else if (w_accept) w_next_state = CHECK;
      CHECK:   if (r_idx == 2'd3) w_next_state = REPLY;
      REPLY:   if (ask_ready) w_next_state = r_correct ? DONE : IDLE;
      DONE:    if (w_load) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Secret, question capture, digit-serial accumulation and reply registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_secret      <= DEFAULT_SECRET;
      r_q           <= '0;
      r_idx         <= 2'd0;
      r_acc_strike  <= '0;
      r_acc_ball    <= '0;
      r_acc_invalid <= 1'b0;
      r_strike      <= '0;
      r_ball        <= '0;
      r_correct     <= 1'b0;
      r_invalid     <= 1'b0;
      r_cnt         <= '0;
      r_secret_err  <= 1'b0;
    end else begin
      r_secret_err <= w_reject;
      if (w_load) begin
        r_secret  <= secret_in;
        r_strike  <= '0;
        r_ball    <= '0;
        r_correct <= 1'b0;
        r_invalid <= 1'b0;
        r_cnt     <= '0;
      end else if (w_accept) begin
        r_q           <= question;
        r_idx         <= 2'd0;
        r_acc_strike  <= '0;
        r_acc_ball    <= '0;
        r_acc_invalid <= 1'b0;
      end else if (r_state == CHECK) begin
        r_idx         <= r_idx + 2'd1;
        r_acc_strike  <= w_next_strike;
        r_acc_ball    <= w_next_ball;
        r_acc_invalid <= w_next_invalid;
        if (r_idx == 2'd3) begin
          r_invalid <= w_next_invalid;
          if (w_next_invalid) begin
            r_strike  <= '0;
            r_ball    <= '0;
            r_correct <= 1'b0;
          end else begin
            r_strike  <= w_next_strike;
            r_ball    <= w_next_ball;
            r_correct <= (w_next_strike == SCORE_W'(NUM_DIGITS));
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign strike     = r_strike;
  assign ball       = r_ball;
  assign correct    = r_correct;
  assign invalid    = r_invalid;
  assign cnt        = r_cnt;
  assign secret_err = r_secret_err;

endmodule

// File: tb/tb_grader.sv
// Self-checking bench for grader: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the game.
module tb_grader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ask_valid = 1'b0;
  logic        ask_ready = 1'b0;
  logic [15:0] question = 16'h0;
  logic        secret_load = 1'b0;
  logic [15:0] secret_in = 16'h0;
  logic        reply_ready, reply_valid, correct, invalid, secret_err;
  logic [2:0]  strike, ball;
  logic [15:0] cnt;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  grader #(.DEFAULT_SECRET(16'h0123), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .ask_valid   (ask_valid),
    .ask_ready   (ask_ready),
    .question    (question),
    .secret_load (secret_load),
    .secret_in   (secret_in),
    .reply_ready (reply_ready),
    .reply_valid (reply_valid),
    .strike      (strike),
    .ball        (ball),
    .correct     (correct),
    .invalid     (invalid),
    .cnt         (cnt),
    .secret_err  (secret_err)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       inv;
    logic [2:0] st;
    logic [2:0] bl;
  } score_t;

  function automatic int nib(input logic [15:0] w, input int i);
    return int'((w >> (12 - 4 * i)) & 16'hF);
  endfunction

  function automatic bit secret_ok(input logic [15:0] s);
    bit ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (nib(s, i) > 9) ok = 1'b0;
      for (int j = 0; j < 4; j++) if (i != j && nib(s, i) == nib(s, j)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic score_t score_of(input logic [15:0] q, input logic [15:0] s);
    score_t r;
    int st = 0, bl = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (nib(q, i) == nib(s, j)) begin
          if (i == j) st++;
          else bl++;
        end
    r.inv = !secret_ok(q);
    r.st  = r.inv ? 3'd0 : 3'(st);
    r.bl  = r.inv ? 3'd0 : 3'(bl);
    return r;
  endfunction

  localparam int P_WAIT = 0, P_SCORE = 1, P_REPLY = 2, P_DONE = 3;

  int          m_phase, m_timer;
  logic [15:0] m_secret, m_q, m_cnt;
  logic [2:0]  m_strike, m_ball;
  logic        m_correct, m_invalid, m_err;
  score_t      w_sc;

  assign w_sc = score_of(m_q, m_secret);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_WAIT; m_timer <= 0; m_secret <= 16'h0123; m_q <= 16'h0;
      m_cnt <= 16'h0; m_strike <= 3'd0; m_ball <= 3'd0;
      m_correct <= 1'b0; m_invalid <= 1'b0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if ((m_phase == P_WAIT || m_phase == P_DONE) && secret_load) begin
        if (secret_ok(secret_in)) begin
          m_secret <= secret_in; m_cnt <= 16'h0; m_strike <= 3'd0; m_ball <= 3'd0;
          m_correct <= 1'b0; m_invalid <= 1'b0; m_phase <= P_WAIT;
        end else begin
          m_err <= 1'b1;
        end
      end else begin
        case (m_phase)
          P_WAIT: if (ask_valid) begin m_q <= question; m_timer <= 3; m_phase <= P_SCORE; end
          P_SCORE:
            if (m_timer == 0) begin
              m_phase   <= P_REPLY;
              m_invalid <= w_sc.inv;
              m_strike  <= w_sc.st;
              m_ball    <= w_sc.bl;
              m_correct <= !w_sc.inv && w_sc.st == 3'd4;
              if (!w_sc.inv && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            end else begin
              m_timer <= m_timer - 1;
            end
          P_REPLY: if (ask_ready) m_phase <= m_correct ? P_DONE : P_WAIT;
          default: ;
        endcase
      end
    end
  end

  // Compare process: mid-cycle, after the DUT and model have both updated.
  always begin
    @(posedge clk);
    #3;
    if (cmp_en) begin
      check("cyc_reply_ready", reply_ready, int'(m_phase == P_WAIT));
      check("cyc_reply_valid", reply_valid, int'(m_phase == P_REPLY));
      check("cyc_secret_err", secret_err, m_err);
      check("cyc_cnt", cnt, m_cnt);
      if (m_phase == P_REPLY || m_phase == P_DONE) begin
        check("cyc_strike", strike, m_strike);
        check("cyc_ball", ball, m_ball);
        check("cyc_correct", correct, m_correct);
        check("cyc_invalid", invalid, m_invalid);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ask(input logic [15:0] q);
    int n = 0;
    while (!reply_ready && n < 50) begin cyc(); n++; end
    check("ask_ready_wait", reply_ready, 1);
    ask_valid = 1'b1; question = q;
    cyc();
    ask_valid = 1'b0; question = 16'($urandom);
  endtask

  task automatic await_reply(output int lat);
    lat = 0;
    while (!reply_valid && lat < 20) begin cyc(); lat++; end
    check("reply_wait", reply_valid, 1);
  endtask

  task automatic ack();
    ask_ready = 1'b1; cyc(); ask_ready = 1'b0;
  endtask

  task automatic load(input logic [15:0] s);
    secret_load = 1'b1; secret_in = s; cyc(); secret_load = 1'b0;
  endtask

  task automatic expect_reply(input string tag, input int st, input int bl,
                              input int cr, input int inv, input int c);
    check({tag, "_strike"}, strike, st);
    check({tag, "_ball"}, ball, bl);
    check({tag, "_correct"}, correct, cr);
    check({tag, "_invalid"}, invalid, inv);
    check({tag, "_cnt"}, cnt, c);
  endtask

  function automatic logic [15:0] gen_digits();
    logic [15:0] v = 16'h0;
    for (int i = 0; i < 4; i++) v = (v << 4) | 16'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [15:0] gen_secret();
    logic [15:0] v = gen_digits();
    if ($urandom_range(0, 3) != 0)
      for (int t = 0; t < 30 && !secret_ok(v); t++) v = gen_digits();
    return v;
  endfunction

  function automatic logic [15:0] gen_q(input logic [15:0] s);
    int r = int'($urandom_range(0, 3));
    int k = int'($urandom_range(0, 3));
    logic [31:0] d = {s, s};
    case (r)
      0:       return s;
      1:       return 16'($urandom);
      2:       return gen_digits();
      default: return d[31 - 4 * k -: 16];
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    score_t sc;

    // Pin the model against hand-scored cases.
    sc = score_of(16'h4321, 16'h1234);
    check("model_4321_st", sc.st, 0); check("model_4321_bl", sc.bl, 4);
    sc = score_of(16'h1567, 16'h1234);
    check("model_1567_st", sc.st, 1); check("model_1567_bl", sc.bl, 0);
    sc = score_of(16'h12A4, 16'h1234);
    check("model_12A4_inv", sc.inv, 1);
    check("model_5578_ok", secret_ok(16'h5578), 0);

    // Reset state.
    repeat (3) cyc();
    check("rst_reply_ready", reply_ready, 1);
    check("rst_reply_valid", reply_valid, 0);
    check("rst_secret_err", secret_err, 0);
    expect_reply("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // Rejected secret, then a winning guess against the default secret.
    load(16'h5578);
    check("err_pulse", secret_err, 1);
    cyc();
    check("err_pulse_end", secret_err, 0);
    ask(16'h0123);
    check("check_ready_low", reply_ready, 0);
    await_reply(lat);
    check("latency", lat, 4);
    expect_reply("win", 4, 0, 1, 0, 1);
    cyc();
    ack();
    check("done_valid", reply_valid, 0);
    check("done_ready", reply_ready, 0);
    cyc();
    check("done_hold_ready", reply_ready, 0);
    expect_reply("done_hold", 4, 0, 1, 0, 1);

    // New game with 1234.
    load(16'h1234);
    check("load_err", secret_err, 0);
    check("load_ready", reply_ready, 1);
    check("load_cnt", cnt, 0);
    ask(16'h4321);
    await_reply(lat);
    expect_reply("q4321", 0, 4, 0, 0, 1);
    ack();
    check("ack1_ready", reply_ready, 1);
    ask(16'h1567);
    await_reply(lat);
    expect_reply("q1567", 1, 0, 0, 0, 2);
    ack();
    check("ack2_ready", reply_ready, 1);

    // Malformed questions.
    ask(16'h1123);
    await_reply(lat);
    expect_reply("q1123", 0, 0, 0, 1, 2);
    ack();
    ask(16'h12A4);
    await_reply(lat);
    expect_reply("q12A4", 0, 0, 0, 1, 2);
    ack();

    // Reply held while question/ask_valid wiggle.
    ask(16'h4321);
    await_reply(lat);
    for (int i = 0; i < 5; i++) begin
      ask_valid = 1'($urandom); question = 16'($urandom);
      cyc();
      check("hold_valid", reply_valid, 1);
      expect_reply("hold", 0, 4, 0, 0, 3);
    end
    ask_valid = 1'b0;
    ack();
    check("hold_ack_ready", reply_ready, 1);

    // Reset in the middle of scoring.
    ask(16'h1234);
    cyc(); cyc();
    check("midcheck_busy", reply_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", reply_ready, 1);
    check("midrst_valid", reply_valid, 0);
    expect_reply("midrst", 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    ask(16'h0123);
    await_reply(lat);
    expect_reply("post_rst", 4, 0, 1, 0, 1);
    ack();

    // Randomized traffic, checked every cycle against the model.
    load(16'h7395);
    for (int n = 0; n < 3000; n++) begin
      ask_valid   = ($urandom_range(0, 2) != 0);
      question    = gen_q(m_secret);
      ask_ready   = ($urandom_range(0, 2) == 0);
      secret_load = ($urandom_range(0, 24) == 0);
      secret_in   = gen_secret();
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
    end
    ask_valid = 1'b0; ask_ready = 1'b0; secret_load = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
